// File: rtl/timer_bridge_ctrl.sv
// CPU-to-timer bridge: address decode, write/read sequencing, IRQ pending/mask and HWInt generation.
// Optional macro BRIDGE_BUSERR_EN adds a sticky bus-error bit (PEND[2]) raised by unmapped accesses.
module timer_bridge_ctrl #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7f00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7f10,
  parameter logic [31:0] CTRL_BASE = 32'h0000_7f20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic        dev0_we,
  output logic        dev1_we,
  input  logic [31:0] dev0_rdata,
  input  logic [31:0] dev1_rdata,
  input  logic [1:0]  dev_irq,
  output logic [5:0]  hwint
);

`ifdef BRIDGE_BUSERR_EN
  localparam int PW = 3;
`else
  localparam int PW = 2;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD1, S_RD2, S_DONE} state_t;

  state_t        r_state, w_next;
  logic          r_sel1;
  logic [31:0]   r_cpu_rdata, r_dev_addr, r_dev_wdata;
  logic [1:0]    r_irq_prev;
  logic [PW-1:0] r_pend, r_mask, w_set, w_clr;
  logic [5:0]    r_hwint;

  logic [31:0] w_off0, w_off1, w_offc, w_ctrl_rdata;
  logic        w_hit0, w_hit1, w_hit_pend, w_hit_mask, w_dev, w_accept;
  logic [1:0]  w_rise;

  assign w_off0     = cpu_addr - DEV0_BASE;
  assign w_off1     = cpu_addr - DEV1_BASE;
  assign w_offc     = cpu_addr - CTRL_BASE;
  assign w_hit0     = (w_off0 == 32'h0) | (w_off0 == 32'h4) | (w_off0 == 32'h8);
  assign w_hit1     = (w_off1 == 32'h0) | (w_off1 == 32'h4) | (w_off1 == 32'h8);
  assign w_hit_pend = (w_offc == 32'h0);
  assign w_hit_mask = (w_offc == 32'h4);
  assign w_dev      = w_hit0 | w_hit1;
  assign w_accept   = (r_state == S_IDLE) & cpu_req;

  assign w_ctrl_rdata = w_hit_pend ? {{(32-PW){1'b0}}, r_pend} :
                        w_hit_mask ? {{(32-PW){1'b0}}, r_mask} : 32'h0;

  // Rising-edge detect; a simultaneous W1C loses to a new set.
  assign w_rise = dev_irq & ~r_irq_prev;
  assign w_clr  = (w_accept & cpu_we & w_hit_pend) ? cpu_wdata[PW-1:0] : '0;
`ifdef BRIDGE_BUSERR_EN
  assign w_set  = {w_accept & ~w_dev & ~w_hit_pend & ~w_hit_mask, w_rise};
`else
  assign w_set  = w_rise;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (cpu_req) w_next = w_dev ? (cpu_we ? S_WR : S_RD1) : S_DONE;
      S_WR:   w_next = S_DONE;
      S_RD1:  w_next = S_RD2;
      S_RD2:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_done = 1'b0;
    dev0_we  = 1'b0;
    dev1_we  = 1'b0;
    case (r_state)
      S_WR:   begin dev0_we = ~r_sel1; dev1_we = r_sel1; end
      S_DONE: cpu_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dev_addr  <= '0;
      r_dev_wdata <= '0;
      r_sel1      <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_dev_addr  <= cpu_addr;
        r_dev_wdata <= cpu_wdata;
        r_sel1      <= w_hit1;
        if (!w_dev && !cpu_we) r_cpu_rdata <= w_ctrl_rdata;
      end
      // Device output is valid one cycle after it sampled dev_addr in RD1.
      if (r_state == S_RD2) r_cpu_rdata <= r_sel1 ? dev1_rdata : dev0_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_prev <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_hwint    <= '0;
    end else begin
      r_irq_prev <= dev_irq;
      r_pend     <= (r_pend & ~w_clr) | w_set;
      if (w_accept && cpu_we && w_hit_mask) r_mask <= cpu_wdata[PW-1:0];
      r_hwint    <= {{(6-PW){1'b0}}, r_pend & r_mask};
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign dev_addr  = r_dev_addr;
  assign dev_wdata = r_dev_wdata;
  assign hwint     = r_hwint;

endmodule

// File: tb/tb_timer_bridge_ctrl.sv
// Bench for timer_bridge_ctrl: timer stubs, transaction-level reference model, directed and random steps.
module tb_timer_bridge_ctrl;
`ifdef BRIDGE_BUSERR_EN
  localparam int PW = 3;
`else
  localparam int PW = 2;
`endif

  logic        clk = 1'b0, reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_done, dev0_we, dev1_we;
  logic [31:0] cpu_rdata, dev_addr, dev_wdata;
  logic [31:0] dev0_rdata = '0, dev1_rdata = '0;
  logic [1:0]  dev_irq = '0;
  logic [5:0]  hwint;

  always #5 clk = ~clk;

  timer_bridge_ctrl dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev0_we(dev0_we), .dev1_we(dev1_we), .dev0_rdata(dev0_rdata),
    .dev1_rdata(dev1_rdata), .dev_irq(dev_irq), .hwint(hwint)
  );

  // Timer stubs: registered read port, write on enable.
  logic [31:0] d0[4] = '{32'h0, 32'h0, 32'h31, 32'h0};
  logic [31:0] d1[4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  int          n_we0 = 0, n_we1 = 0, n_both = 0;
  logic [31:0] last_wd = '0;

  always @(posedge clk) begin
    if (dev0_we) begin d0[dev_addr[3:2]] <= dev_wdata; n_we0 <= n_we0 + 1; last_wd <= dev_wdata; end
    if (dev1_we) begin d1[dev_addr[3:2]] <= dev_wdata; n_we1 <= n_we1 + 1; last_wd <= dev_wdata; end
    if (dev0_we && dev1_we) n_both <= n_both + 1;
    dev0_rdata <= d0[dev_addr[3:2]];
    dev1_rdata <= d1[dev_addr[3:2]];
  end

  int vecs = 0, errs = 0;
  logic [31:0] m_d0[4] = '{32'h0, 32'h0, 32'h31, 32'h0};
  logic [31:0] m_d1[4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic [PW-1:0] m_pend = '0, m_mask = '0;
  logic [1:0]    m_irq = '0;
  logic [31:0]   alist[12] = '{32'h7f00, 32'h7f04, 32'h7f08, 32'h7f0c, 32'h7f10, 32'h7f14,
                               32'h7f18, 32'h7f1c, 32'h7f20, 32'h7f24, 32'h7f28, 32'h1234};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 timer0, 1 timer1, 2 PEND, 3 MASK, 4 unmapped (word-aligned addresses only)
  function automatic int kind_of(input logic [31:0] a);
    if (a >= 32'h7f00 && a <= 32'h7f08) return 0;
    if (a >= 32'h7f10 && a <= 32'h7f18) return 1;
    if (a == 32'h7f20) return 2;
    if (a == 32'h7f24) return 3;
    return 4;
  endfunction

  function automatic logic [5:0] exp_hw();
    return 6'(m_pend & m_mask);
  endfunction

  task automatic do_xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] irq_new);
    int k, idx, lat, exp_lat, c0, c1;
    logic [31:0] exp_rd;
    logic [1:0]  rise;
    k = kind_of(a);
    idx = int'(a[3:2]);
    case (k)
      0: exp_rd = m_d0[idx];
      1: exp_rd = m_d1[idx];
      2: exp_rd = 32'(m_pend);
      3: exp_rd = 32'(m_mask);
      default: exp_rd = 32'h0;
    endcase
    exp_lat = (k < 2) ? (we ? 2 : 3) : 1;
    c0 = n_we0; c1 = n_we1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; dev_irq = irq_new;
    @(posedge clk);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cpu_done && lat < 10);
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk($sformatf("latency@%h", a), 32'(lat), 32'(exp_lat));
    if (!we) chk($sformatf("rdata@%h", a), cpu_rdata, exp_rd);
    rise = irq_new & ~m_irq;
    m_irq = irq_new;
    if (we) begin
      case (k)
        0: m_d0[idx] = wd;
        1: m_d1[idx] = wd;
        2: m_pend = m_pend & ~wd[PW-1:0];
        3: m_mask = wd[PW-1:0];
        default: ;
      endcase
    end
`ifdef BRIDGE_BUSERR_EN
    if (k == 4) m_pend[2] = 1'b1;
`endif
    m_pend = m_pend | PW'(rise);
    @(negedge clk);
    chk("done_pulse", {31'b0, cpu_done}, 32'h0);
    if (!we) chk("rdata_hold", cpu_rdata, exp_rd);
    chk("we0_count", 32'(n_we0 - c0), (we && k == 0) ? 32'h1 : 32'h0);
    chk("we1_count", 32'(n_we1 - c1), (we && k == 1) ? 32'h1 : 32'h0);
    if (we && k < 2) chk("dev_wdata", last_wd, wd);
    chk("hwint", {26'b0, hwint}, {26'b0, exp_hw()});
  endtask

  task automatic irq_set(input logic [1:0] v);
    @(negedge clk);
    dev_irq = v;
    m_pend = m_pend | PW'(v & ~m_irq);
    m_irq = v;
    @(negedge clk);
    @(negedge clk);
    chk("hwint_irq", {26'b0, hwint}, {26'b0, exp_hw()});
  endtask

  initial begin
    #1;
    chk("rst_done", {31'b0, cpu_done}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_addr", dev_addr, 32'h0);
    chk("rst_wdata", dev_wdata, 32'h0);
    chk("rst_we", {30'b0, dev1_we, dev0_we}, 32'h0);
    chk("rst_hwint", {26'b0, hwint}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    do_xact(1'b1, 32'h7f14, 32'h64, 2'b00);
    do_xact(1'b0, 32'h7f08, 32'h0, 2'b00);
    do_xact(1'b0, 32'h7f14, 32'h0, 2'b00);

    do_xact(1'b1, 32'h7f24, 32'h1, 2'b00);
    irq_set(2'b01);
    do_xact(1'b0, 32'h7f20, 32'h0, 2'b01);
    do_xact(1'b1, 32'h7f20, 32'h1, 2'b01);
    irq_set(2'b00);
    do_xact(1'b1, 32'h7f20, 32'h1, 2'b01);
    do_xact(1'b0, 32'h7f20, 32'h0, 2'b01);

    do_xact(1'b1, 32'h7f24, 32'h0, 2'b01);
    irq_set(2'b11);
    do_xact(1'b1, 32'h7f24, 32'h2, 2'b11);
    do_xact(1'b0, 32'h7f24, 32'h0, 2'b11);

    do_xact(1'b0, 32'h7f0c, 32'h0, 2'b11);
    do_xact(1'b1, 32'h7f1c, 32'hdead, 2'b11);
`ifdef BRIDGE_BUSERR_EN
    do_xact(1'b1, 32'h7f24, 32'h4, 2'b11);
    do_xact(1'b1, 32'h7f20, 32'h3, 2'b11);
`endif
    do_xact(1'b1, 32'h7f20, 32'hffff_ffff, 2'b00);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) irq_set(2'($urandom_range(0, 3)));
      do_xact(1'($urandom_range(0, 1)), alist[$urandom_range(0, 11)], $urandom, m_irq);
    end

    // Reset during RD1 aborts the access.
    irq_set(2'b00);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7f00;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_done", {31'b0, cpu_done}, 32'h0);
    chk("abort_rdata", cpu_rdata, 32'h0);
    chk("abort_addr", dev_addr, 32'h0);
    chk("abort_wdata", dev_wdata, 32'h0);
    chk("abort_hwint", {26'b0, hwint}, 32'h0);
    cpu_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_nodone", {31'b0, cpu_done}, 32'h0);
    end
    reset = 1'b1;
    m_pend = '0; m_mask = '0; m_irq = '0;
    do_xact(1'b0, 32'h7f08, 32'h0, 2'b00);
    do_xact(1'b1, 32'h7f04, 32'h1234_5678, 2'b00);
    do_xact(1'b0, 32'h7f04, 32'h0, 2'b00);

    chk("we_exclusive", 32'(n_both), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/timer_bridge_ctrl.md
Name: timer_bridge_ctrl

Overview:
- Bridge/controller between the CPU data port and two memory-mapped timer devices (ctrl/preset/count at offsets 0x0/0x4/0x8).
- Decodes the CPU address, sequences device writes and registered reads through a small state machine, and returns results with a done handshake.
- Latches timer IRQs into pending bits with mask and clear registers, and drives HWInt lines to CP0.

Parameters:
- DEV0_BASE, 32'h0000_7f00, base of timer 0 window (offsets 0x0..0x8)
- DEV1_BASE, 32'h0000_7f10, base of timer 1 window (offsets 0x0..0x8)
- CTRL_BASE, 32'h0000_7f20, bridge regs: +0x0 PEND (read; write-1-to-clear), +0x4 MASK (R/W, bits[1:0])

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request; held with addr/we/wdata until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address; word aligned
- cpu_wdata  in  32  write data
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data; valid while cpu_done=1, held afterwards
- dev_addr  out  32  address to both timers
- dev_wdata  out  32  write data to both timers
- dev0_we  out  1  timer 0 write enable
- dev1_we  out  1  timer 1 write enable
- dev0_rdata  in  32  timer 0 DataOut (registered in device, 1-cycle latency)
- dev1_rdata  in  32  timer 1 DataOut
- dev_irq  in  2  IRQ from timer1, timer0
- hwint  out  6  HWInt[7:2] to CP0

Behaviour:
- Reset (reset=0, async): state=IDLE; cpu_done=0, cpu_rdata=0, dev_addr=0, dev_wdata=0, dev0_we=dev1_we=0, PEND=0, MASK=0, hwint=0, irq_prev=0. Reset mid-access aborts the access; no cpu_done is issued.
- Decode: word offset = addr - base; hit only when offset is 0x0, 0x4 or 0x8 (DEV windows) or 0x0, 0x4 (CTRL). Everything else is unmapped.
- States: IDLE, WR, RD1, RD2, DONE.
- IDLE: when cpu_req=1, register addr/wdata onto dev_addr/dev_wdata.
  - Device write -> WR.
  - Device read -> RD1.
  - CTRL access or unmapped -> DONE, performing the CTRL write or read (unmapped read returns 0; unmapped write is ignored).
- WR: selected devX_we=1 for exactly this cycle -> DONE.
- RD1: device samples dev_addr at this edge; we=0 -> RD2.
- RD2: capture the selected devX_rdata into cpu_rdata -> DONE.
- DONE: cpu_done=1 for one cycle -> IDLE. A new request is accepted no earlier than the cycle after DONE.
- Latency from req seen in IDLE to cpu_done: write 2 cycles, device read 3, CTRL/unmapped 1.
- IRQ pending:
  - irq_prev <= dev_irq each cycle; PEND[i] sets on a rising edge of dev_irq[i].
  - A CTRL+0x0 write clears the PEND bits whose wdata bits are 1.
  - Set and clear in the same cycle: set wins.
- hwint = {4'b0, PEND & MASK}, registered (1 cycle after PEND/MASK update).
- MASK write takes bits [1:0] only; reads return zero-extended values.
- Only one device write enable may be high in any cycle; both are 0 outside WR.

Optional Feature:
- BRIDGE_BUSERR_EN defined:
  - Unmapped access sets sticky ERR (PEND bit 2, cleared by W1C bit 2).
  - hwint[2] = ERR & MASK[2]; MASK becomes 3 bits wide.
- Undefined:
  - Unmapped accesses are silently ignored.
  - hwint[5:2] stay 0; PEND bit 2 reads 0.

Test Plan:
- Write 0x0000_0064 to 0x7f14 -> dev1_we high exactly 1 cycle, dev_wdata=0x64, dev0_we=0, cpu_done 2 cycles after accept.
- Read 0x7f08 with dev0_rdata=0x0000_0031 presented by the model after RD1 -> cpu_rdata=0x31 with cpu_done 3 cycles after accept.
- Write MASK=0x1; pulse dev_irq[0] rising -> PEND=0x1, hwint=0x01. Write 0x1 to 0x7f20 -> hwint=0. Rising edge on the same cycle as the clear -> PEND stays 1.
- Leave dev_irq[1] rising with MASK=0 -> PEND bit1=1, hwint=0. Then write MASK=0x2 -> hwint=0x02.
- Read unmapped 0x7f0c -> cpu_rdata=0, done after 1 cycle, no we pulse. With BRIDGE_BUSERR_EN and MASK=0x4 -> hwint=0x04.
- Assert reset=0 asynchronously during RD1 -> all outputs 0 immediately, no cpu_done. After release, next request completes normally.
